lcd_bus_receiver: RTL and testbench

- Device-side decoder for the 4-bit HD44780-style LCD bus that the board-level LCD controller drives.
- Watches E/RS/RW/D[3:0] in the same clock domain. It tracks the power-on 8-bit to 4-bit mode switch, reassembles high/low nibble pairs into bytes, and flags protocol/timing violations.
- Keeps a shadow DDRAM cursor address.
- Used as a loopback checker in simulation and on-chip debug of the LCD path.

---
 rtl/lcd_bus_receiver_if.sv | 24 ++
 rtl/lcd_bus_receiver.sv | 147 ++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_receiver_if.sv
// LCD 4-bit bus plus decoded-result signals shared by the controller side and the receiver.
interface lcd_bus_receiver_if;
  logic       iLCD_Enabled;
  logic       iLCD_RegisterSelect;
  logic       iLCD_ReadWrite;
  logic [3:0] iLCD_Data;
  logic [7:0] oByte;
  logic       oIsData;
  logic       oByteValid;
  logic       oFourBitMode;
  logic [6:0] oCursorAddr;
  logic       oPulseError;
  logic       oProtocolError;

  modport master (
    output iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite, iLCD_Data,
    input  oByte, oIsData, oByteValid, oFourBitMode, oCursorAddr, oPulseError, oProtocolError
  );

  modport slave (
    input  iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite, iLCD_Data,
    output oByte, oIsData, oByteValid, oFourBitMode, oCursorAddr, oPulseError, oProtocolError
  );
endinterface

// File: rtl/lcd_bus_receiver.sv
// HD44780-style 4-bit bus decoder: init tracking, nibble pairing, shadow cursor, error flags.
module lcd_bus_receiver #(
  parameter int unsigned MIN_E_HIGH     = 12,
  parameter int unsigned NIBBLE_TIMEOUT = 50000
) (
  input logic Clock,
  input logic Reset,
  lcd_bus_receiver_if.slave bus
);

  localparam int unsigned EW = $clog2(MIN_E_HIGH + 1);
  localparam int unsigned TW = $clog2(NIBBLE_TIMEOUT + 1);

  typedef enum logic [1:0] {INIT8, HIGH, LOW} state_t;

  state_t        state;
  logic          e_r;
  logic          rs_r;
  logic          rw_r;
  logic [3:0]    d_r;
  logic [EW-1:0] e_cnt;
  logic [TW-1:0] to_cnt;
  logic [1:0]    init_cnt;
  logic [3:0]    hi;
  logic          hi_rs;
  logic          inc_mode;

  logic       fall_c;
  logic       width_ok_c;
  logic       nibble_ok_c;
  logic [7:0] asm_byte_c;

  assign fall_c      = e_r & ~bus.iLCD_Enabled;
  assign width_ok_c  = (e_cnt >= EW'(MIN_E_HIGH));
  assign nibble_ok_c = fall_c & width_ok_c & ~rw_r;
  assign asm_byte_c  = {hi, d_r};

  // One-step cursor move with the 2x40 line wrap.
  function automatic logic [6:0] cursor_step(input logic [6:0] addr, input logic inc);
    if (inc) begin
      if (addr == 7'h27) return 7'h40;
      if (addr == 7'h67) return 7'h00;
      return addr + 7'd1;
    end
    if (addr == 7'h00) return 7'h67;
    if (addr == 7'h40) return 7'h27;
    return addr - 7'd1;
  endfunction

  // Input sampling and saturating E-high width counter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      e_r   <= 1'b0;
      rs_r  <= 1'b0;
      rw_r  <= 1'b0;
      d_r   <= 4'h0;
      e_cnt <= '0;
    end else begin
      e_r  <= bus.iLCD_Enabled;
      rs_r <= bus.iLCD_RegisterSelect;
      rw_r <= bus.iLCD_ReadWrite;
      d_r  <= bus.iLCD_Data;
      if (!bus.iLCD_Enabled)
        e_cnt <= '0;
      else if (e_cnt != EW'(MIN_E_HIGH))
        e_cnt <= e_cnt + EW'(1);
    end
  end

  // Protocol FSM, byte assembly, cursor shadow and registered pulses.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state              <= INIT8;
      init_cnt           <= 2'd0;
      to_cnt             <= '0;
      hi                 <= 4'h0;
      hi_rs              <= 1'b0;
      inc_mode           <= 1'b1;
      bus.oByte          <= 8'h00;
      bus.oIsData        <= 1'b0;
      bus.oByteValid     <= 1'b0;
      bus.oFourBitMode   <= 1'b0;
      bus.oCursorAddr    <= 7'h00;
      bus.oPulseError    <= 1'b0;
      bus.oProtocolError <= 1'b0;
    end else begin
      bus.oByteValid     <= 1'b0;
      bus.oPulseError    <= 1'b0;
      bus.oProtocolError <= 1'b0;

      if (fall_c && !width_ok_c)
        bus.oPulseError <= 1'b1;
      else if (fall_c && rw_r)
        bus.oProtocolError <= 1'b1;

      case (state)
        INIT8: begin
          if (nibble_ok_c) begin
            if (!rs_r && d_r == 4'h3) begin
              if (init_cnt != 2'd3) init_cnt <= init_cnt + 2'd1;
            end else if (!rs_r && d_r == 4'h2 && init_cnt == 2'd3) begin
              state            <= HIGH;
              bus.oFourBitMode <= 1'b1;
            end else begin
              bus.oProtocolError <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (nibble_ok_c) begin
            hi     <= d_r;
            hi_rs  <= rs_r;
            to_cnt <= '0;
            state  <= LOW;
          end
        end
        LOW: begin
          if (nibble_ok_c) begin
            state <= HIGH;
            if (rs_r != hi_rs) begin
              bus.oProtocolError <= 1'b1;
            end else begin
              bus.oByte      <= asm_byte_c;
              bus.oIsData    <= hi_rs;
              bus.oByteValid <= 1'b1;
              if (hi_rs)
                bus.oCursorAddr <= cursor_step(bus.oCursorAddr, inc_mode);
              else if (asm_byte_c == 8'h01 || asm_byte_c == 8'h02 || asm_byte_c == 8'h03)
                bus.oCursorAddr <= 7'h00;
              else if (asm_byte_c[7:2] == 6'b000001)
                inc_mode <= asm_byte_c[1];
              else if (asm_byte_c[7])
                bus.oCursorAddr <= asm_byte_c[6:0];
            end
          end else if (to_cnt == TW'(NIBBLE_TIMEOUT - 1)) begin
            bus.oProtocolError <= 1'b1;
            state              <= HIGH;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: state <= INIT8;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Scoreboard bench for lcd_bus_receiver: drives nibble pulses, checks bytes, cursor and error pulses.
module tb_lcd_bus_receiver;

  localparam int unsigned MIN_E = 12;
  localparam int unsigned TMO   = 200;

  logic Clock;
  logic Reset;

  lcd_bus_receiver_if bus ();

  lcd_bus_receiver #(.MIN_E_HIGH(MIN_E), .NIBBLE_TIMEOUT(TMO)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] b;
    logic       rs;
    logic [6:0] a;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int pe_seen  = 0;
  int pr_seen  = 0;
  int pe_exp   = 0;
  int pr_exp   = 0;

  logic [6:0] m_addr = 7'h00;
  logic       m_inc  = 1'b1;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Byte/cursor scoreboard and error pulse counters.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (bus.oByteValid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(bus.oByte), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("byte", 32'(bus.oByte), 32'(e.b));
          check("is_data", 32'(bus.oIsData), 32'(e.rs));
          check("cursor", 32'(bus.oCursorAddr), 32'(e.a));
        end
      end
      if (bus.oPulseError) pe_seen++;
      if (bus.oProtocolError) pr_seen++;
    end
  end

  task automatic nib(input logic rs, input logic rw, input logic [3:0] d, input int width);
    bus.iLCD_RegisterSelect = rs;
    bus.iLCD_ReadWrite      = rw;
    bus.iLCD_Data           = d;
    bus.iLCD_Enabled        = 1'b1;
    repeat (width) @(posedge Clock);
    #1 bus.iLCD_Enabled = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
  endtask

  // Reference cursor: split into line/column so wrap is "column 39 <-> column 0, swap line".
  task automatic model_byte(input logic rs, input logic [7:0] b);
    logic       line;
    logic [5:0] col;
    line = m_addr[6];
    col  = m_addr[5:0];
    if (rs) begin
      if (m_inc) begin
        if (col == 6'd39) begin line = ~line; col = 6'd0; end
        else col = col + 6'd1;
      end else begin
        if (col == 6'd0) begin line = ~line; col = 6'd39; end
        else col = col - 6'd1;
      end
      m_addr = {line, col};
    end else if (b >= 8'h01 && b <= 8'h03) begin
      m_addr = 7'h00;
    end else if (b >= 8'h04 && b <= 8'h07) begin
      m_inc = b[1];
    end else if (b >= 8'h80) begin
      m_addr = b[6:0];
    end
  endtask

  task automatic send_byte_w(input logic rs, input logic [7:0] b, input int width);
    exp_t e;
    model_byte(rs, b);
    e.b = b;
    e.rs = rs;
    e.a = m_addr;
    exp_q.push_back(e);
    nib(rs, 1'b0, b[7:4], width);
    nib(rs, 1'b0, b[3:0], width);
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    send_byte_w(rs, b, 16);
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    m_addr = 7'h00;
    m_inc  = 1'b1;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset                   = 1'b1;
    bus.iLCD_Enabled        = 1'b0;
    bus.iLCD_RegisterSelect = 1'b0;
    bus.iLCD_ReadWrite      = 1'b0;
    bus.iLCD_Data           = 4'h0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset_outputs", 32'({bus.oByte, bus.oIsData, bus.oByteValid, bus.oFourBitMode,
                                bus.oCursorAddr, bus.oPulseError, bus.oProtocolError}), 32'h0);
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;

    // Premature 0x2 after only two 0x3.
    nib(0, 0, 4'h3, 16);
    nib(0, 0, 4'h3, 16);
    nib(0, 0, 4'h2, 16);
    pr_exp++;
    check("early_2_proto", 32'(pr_seen), 32'(pr_exp));
    check("early_2_mode", 32'(bus.oFourBitMode), 32'h0);
    pulse_reset();

    // Clean init sequence.
    nib(0, 0, 4'h3, 16);
    nib(0, 0, 4'h3, 16);
    nib(0, 0, 4'h3, 16);
    check("init_mode_pending", 32'(bus.oFourBitMode), 32'h0);
    nib(0, 0, 4'h2, 16);
    check("init_mode", 32'(bus.oFourBitMode), 32'h1);
    check("init_proto", 32'(pr_seen), 32'(pr_exp));
    check("init_pulse", 32'(pe_seen), 32'(pe_exp));

    // Commands and one data write.
    send_byte(0, 8'h28);
    send_byte(0, 8'h06);
    send_byte(0, 8'h0C);
    send_byte(0, 8'h01);
    send_byte(1, 8'h5A);
    check("cmd_drain", 32'(exp_q.size()), 32'h0);

    // Pulse-width boundary: 5 and 11 rejected, 12 accepted.
    nib(0, 0, 4'h1, 5);
    pe_exp++;
    check("short_pulse_5", 32'(pe_seen), 32'(pe_exp));
    nib(0, 0, 4'h1, MIN_E - 1);
    pe_exp++;
    check("short_pulse_11", 32'(pe_seen), 32'(pe_exp));
    check("short_no_proto", 32'(pr_seen), 32'(pr_exp));
    send_byte_w(1, 8'h62, MIN_E);

    // RS mismatch within a pair, then recovery.
    nib(1, 0, 4'h4, 16);
    nib(0, 0, 4'h1, 16);
    pr_exp++;
    check("rs_mismatch", 32'(pr_seen), 32'(pr_exp));
    send_byte(1, 8'h41);

    // Read strobe is a protocol error and does not advance the pair.
    nib(0, 1, 4'h5, 16);
    pr_exp++;
    check("rw_proto", 32'(pr_seen), 32'(pr_exp));
    send_byte(1, 8'h42);

    // Cursor wrap cases.
    send_byte(0, 8'hA7);
    send_byte(1, 8'h43);
    send_byte(1, 8'h44);
    send_byte(0, 8'h04);
    send_byte(0, 8'h80);
    send_byte(1, 8'h45);
    send_byte(0, 8'hC0);
    send_byte(1, 8'h46);
    send_byte(0, 8'h02);
    send_byte(1, 8'h47);

    // Low nibble never arrives.
    nib(1, 0, 4'h7, 16);
    repeat (TMO + 50) @(posedge Clock);
    #1;
    pr_exp++;
    check("timeout_proto", 32'(pr_seen), 32'(pr_exp));
    send_byte(1, 8'h48);
    check("wrap_drain", 32'(exp_q.size()), 32'h0);
    check("final_pulse_cnt", 32'(pe_seen), 32'(pe_exp));

    // Asynchronous reset in the middle of a pair.
    nib(1, 0, 4'h8, 16);
    Reset = 1'b1;
    #1;
    check("midpair_reset", 32'({bus.oByte, bus.oIsData, bus.oByteValid, bus.oFourBitMode,
                                bus.oCursorAddr, bus.oPulseError, bus.oProtocolError}), 32'h0);
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("post_reset_mode", 32'(bus.oFourBitMode), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
